arb_mux: RTL and testbench

- Parametrised N:1 arbitrating multiplexer with a registered valid/ready output stage.
- Next generation of the datapath 2:1 select mux: one block replaces chains of 2:1 muxes.
- Used where several requesters share one downstream port, e.g. writeback-source or memory-port sharing in the multi-cycle/pipelined datapath.
- Selection comes from internal fixed-priority or round-robin arbitration, not from an external select line.

---
 rtl/arb_mux.sv | 67 ++++++
 tb/tb_arb_mux.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// N:1 arbitrating multiplexer with a registered valid/ready output stage.
// Arbitration is round-robin (RR_MODE=1) or fixed lowest-index priority (RR_MODE=0).
module arb_mux #(
  parameter int WIDTH   = 32,
  parameter int NUM_CH  = 4,
  parameter int RR_MODE = 1,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic [NUM_CH-1:0]       i_Valid,
  input  logic [NUM_CH*WIDTH-1:0] i_Data,
  output logic [NUM_CH-1:0]       o_Ready,
  output logic                    o_Valid,
  output logic [WIDTH-1:0]        o_Data,
  output logic [CH_W-1:0]         o_ChId,
  input  logic                    i_Ready
);

  logic [CH_W-1:0]   ptr;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              found;
  logic              load_en;
  int                idx;

  // Held in reset, the stage must not advertise any accept.
  assign load_en = i_Rst_n & (~o_Valid | i_Ready);
  assign o_Ready = load_en ? grant : '0;

  // Search starts at the pointer and wraps; in fixed-priority mode it starts at 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int o = 0; o < NUM_CH; o++) begin
      idx = (RR_MODE != 0) ? ((int'(ptr) + o) % NUM_CH) : o;
      if (!found && i_Valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Valid <= 1'b0;
      o_Data  <= '0;
      o_ChId  <= '0;
      ptr     <= '0;
    end else if (load_en) begin
      if (found) begin
        o_Valid <= 1'b1;
        o_Data  <= i_Data[int'(grant_idx)*WIDTH +: WIDTH];
        o_ChId  <= grant_idx;
        if (RR_MODE != 0) begin
          ptr <= (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + CH_W'(1);
        end
      end else begin
        o_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: one round-robin and one fixed-priority instance
// share the same stimulus; expected values are hand-computed constants.
module tb_arb_mux;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   valid;
  logic [N*W-1:0] data;
  logic           rdy;

  logic [N-1:0]   rr_ready, fp_ready;
  logic           rr_valid, fp_valid;
  logic [W-1:0]   rr_data, fp_data;
  logic [1:0]     rr_chid, fp_chid;

  int n_vec = 0;
  int n_err = 0;

  arb_mux #(.WIDTH(W), .NUM_CH(N), .RR_MODE(1)) dut_rr (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(valid), .i_Data(data),
    .o_Ready(rr_ready), .o_Valid(rr_valid), .o_Data(rr_data),
    .o_ChId(rr_chid), .i_Ready(rdy)
  );

  arb_mux #(.WIDTH(W), .NUM_CH(N), .RR_MODE(0)) dut_fp (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(valid), .i_Data(data),
    .o_Ready(fp_ready), .o_Valid(fp_valid), .o_Data(fp_data),
    .o_ChId(fp_chid), .i_Ready(rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return at the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [1:0] id, input logic [W-1:0] d);
    chk({tag, "_valid"}, 64'(rr_valid), 64'd1);
    chk({tag, "_chid"},  64'(rr_chid),  64'(id));
    chk({tag, "_data"},  64'(rr_data),  64'(d));
  endtask

  initial begin
    rst_n = 1'b0;
    rdy   = 1'b1;
    valid = 4'b1111;
    for (int k = 0; k < N; k++) data[k*W +: W] = 32'hA0 + k;

    // Reset / idle
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(rr_valid), 64'd0);
    chk("rst_data",  64'(rr_data),  64'd0);
    chk("rst_chid",  64'(rr_chid),  64'd0);
    chk("rst_ready", 64'(rr_ready), 64'd0);
    chk("rst_fp_valid", 64'(fp_valid), 64'd0);
    chk("rst_fp_ready", 64'(fp_ready), 64'd0);

    rst_n = 1'b1;
    #1;
    chk("first_ready", 64'(rr_ready), 64'b0001);

    // Round-robin fairness: 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_out("rr_seq", 2'(i % 4), 32'hA0 + (i % 4));
    end

    // Backpressure: next accept is ch1 carrying DEADBEEF, then stall
    data[1*W +: W] = 32'hDEAD_BEEF;
    #1;
    chk("bp_ready_pre", 64'(rr_ready), 64'b0010);
    cyc();
    chk_out("bp_load", 2'd1, 32'hDEAD_BEEF);
    rdy = 1'b0;
    #1;
    chk("bp_ready_stall", 64'(rr_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("bp_hold", 2'd1, 32'hDEAD_BEEF);
      chk("bp_hold_ready", 64'(rr_ready), 64'd0);
    end
    rdy = 1'b1;
    #1;
    chk("bp_ptr_frozen", 64'(rr_ready), 64'b0100);
    cyc();
    chk_out("bp_nobubble", 2'd2, 32'hA2);

    // Pointer at 3, sparse request on ch0 wraps
    valid = 4'b0001;
    #1;
    chk("wrap_ready", 64'(rr_ready), 64'b0001);
    cyc();
    chk_out("wrap_out", 2'd0, 32'hA0);
    valid = 4'b0000;
    #1;
    chk("idle_ready", 64'(rr_ready), 64'd0);
    cyc();
    chk("idle_valid", 64'(rr_valid), 64'd0);
    valid = 4'b1111;
    #1;
    chk("wrap_ptr1", 64'(rr_ready), 64'b0010);
    cyc();
    chk_out("wrap_next", 2'd1, 32'hDEAD_BEEF);

    // Async reset mid-stall
    rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(rr_valid), 64'd0);
    chk("arst_data",  64'(rr_data),  64'd0);
    chk("arst_ready", 64'(rr_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy   = 1'b1;
    #1;
    chk("arst_ptr0", 64'(rr_ready), 64'b0001);
    cyc();
    chk_out("arst_after", 2'd0, 32'hA0);

    // Fixed priority instance
    data[1*W +: W] = 32'hA1;
    valid = 4'b1010;
    #1;
    chk("fp_ready", 64'(fp_ready), 64'b0010);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("fp_chid", 64'(fp_chid), 64'd1);
      chk("fp_data", 64'(fp_data), 64'hA1);
    end
    valid = 4'b1000;
    #1;
    chk("fp_ready_b3", 64'(fp_ready), 64'b1000);
    cyc();
    chk("fp_chid_b3", 64'(fp_chid), 64'd3);
    chk("fp_data_b3", 64'(fp_data), 64'hA3);
    chk("fp_valid_b3", 64'(fp_valid), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
